// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default constants for the cpu_seq instruction sequencer.
package cpu_pkg;

    // Default interrupt vector table placement
    localparam int unsigned CPU_VEC_BASE   = 'h100;
    localparam int unsigned CPU_VEC_STRIDE = 4;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_BEGIN,
        ST_FETCH,
        ST_EXEC,
        ST_END,
        ST_HLT,
        ST_INT,
        ST_FAULT
    } cpu_state_e;

    // Instruction-pointer update requested by the sequencer for the coming edge
    typedef enum logic [2:0] {
        IP_HOLD,
        IP_INC,
        IP_BR,
        IP_RETI,
        IP_INT
    } ip_op_e;

endpackage

// File: rtl/cpu_seq_if.sv
// cpu_seq_if: RAM fetch bus and execute-unit handshake of the cpu_seq sequencer.
// master = sequencer side, slave = memory / execute-unit side.
interface cpu_seq_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               ram_txs;
    logic               ram_re;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_txe;
    logic               ram_err;
    logic [INSTR_W-1:0] ram_out;

    logic [INSTR_W-1:0] instr;
    logic               ex_start;
    logic               ex_done;
    logic               ex_hlt;
    logic               ex_reti;
    logic               br_set;
    logic [ADDR_W-1:0]  br_addr;

    modport master (
        output ram_txs, ram_re, ram_addr, instr, ex_start,
        input  ram_txe, ram_err, ram_out, ex_done, ex_hlt, ex_reti, br_set, br_addr
    );

    modport slave (
        input  ram_txs, ram_re, ram_addr, instr, ex_start,
        output ram_txe, ram_err, ram_out, ex_done, ex_hlt, ex_reti, br_set, br_addr
    );
endinterface

// File: rtl/cpu_seq_ipu.sv
// cpu_seq_ipu: instruction-pointer unit. Holds ip, the saved return address epc and
// the interrupt-enable flag ie, and computes the interrupt vector address.
// Interrupt support (epc, ie, vectoring) exists only when CPU_SEQ_INT_EN is defined;
// otherwise epc reads 0 and ie stays 1.
module cpu_seq_ipu
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                DEV_ID_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(CPU_VEC_BASE),
    parameter int unsigned       VEC_STRIDE = CPU_VEC_STRIDE
) (
    input  logic                clk,
    input  logic                rst,
    input  ip_op_e              op,
    input  logic [ADDR_W-1:0]   br_addr,
    input  logic [DEV_ID_W-1:0] dev_id,
    output logic [ADDR_W-1:0]   ip,
    output logic [ADDR_W-1:0]   epc,
    output logic                ie
);

`ifdef CPU_SEQ_INT_EN
    logic [ADDR_W-1:0] vec_addr;

    // Vector slot for the requesting device; arithmetic wraps at ADDR_W bits
    assign vec_addr = VEC_BASE + ADDR_W'(dev_id) * ADDR_W'(VEC_STRIDE);

    // ip / epc / ie update: advance, branch, return-from-interrupt or interrupt entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip  <= RESET_VEC;
            epc <= '0;
            ie  <= 1'b1;
        end else begin
            case (op)
                IP_INC:  ip <= ip + ADDR_W'(1);
                IP_BR:   ip <= br_addr;
                IP_RETI: begin
                    ip <= epc;
                    ie <= 1'b1;
                end
                IP_INT:  begin
                    epc <= ip;
                    ip  <= vec_addr;
                    ie  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_dev;

    assign epc        = '0;
    assign ie         = 1'b1;
    assign unused_dev = ^dev_id;

    // ip update: advance (wrapping) or branch; no interrupt state exists in this build
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip <= RESET_VEC;
        end else begin
            case (op)
                IP_INC:  ip <= ip + ADDR_W'(1);
                IP_BR:   ip <= br_addr;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: instruction sequencer. Fetches one word per instruction from RAM, hands it
// to the execute unit and updates the instruction pointer from the result.
// A normal instruction takes BEGIN, FETCH, EXEC, END (4 cycles minimum).
// Optional interrupt support is enabled with the macro CPU_SEQ_INT_EN.
// The interrupt request line is int_req because int is a reserved word.
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                INSTR_W    = 32,
    parameter int                DEV_ID_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(CPU_VEC_BASE),
    parameter int unsigned       VEC_STRIDE = CPU_VEC_STRIDE
) (
    input  logic                clk,
    input  logic                rst,
    cpu_seq_if.master           bus,
    input  logic                int_req,
    input  logic [DEV_ID_W-1:0] int_dev_id,
    output logic                int_ack,
    output logic [ADDR_W-1:0]   ip,
    output logic [ADDR_W-1:0]   epc,
    output logic                hlt,
    output logic                fault
);

    cpu_state_e state;
    cpu_state_e state_nx;
    ip_op_e     ip_op;
    logic       fetch_req;
    logic       fetch_ack;
    logic       instr_ld;
    logic       ie;
    logic       int_take;
    logic       reti_en;

`ifdef CPU_SEQ_INT_EN
    assign int_take = int_req & ie;
    assign reti_en  = 1'b1;
    assign int_ack  = (state == ST_INT);
`else
    logic unused_int;

    assign int_take   = 1'b0;
    assign reti_en    = 1'b0;
    assign int_ack    = 1'b0;
    assign unused_int = ^{int_req, ie};
`endif

    assign hlt   = (state == ST_HLT) || (state == ST_FAULT);
    assign fault = (state == ST_FAULT);

    cpu_seq_ipu #(
        .ADDR_W     (ADDR_W),
        .DEV_ID_W   (DEV_ID_W),
        .RESET_VEC  (RESET_VEC),
        .VEC_BASE   (VEC_BASE),
        .VEC_STRIDE (VEC_STRIDE)
    ) u_ipu (
        .clk     (clk),
        .rst     (rst),
        .op      (ip_op),
        .br_addr (bus.br_addr),
        .dev_id  (int_dev_id),
        .ip      (ip),
        .epc     (epc),
        .ie      (ie)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BEGIN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state control decode; interrupts are only taken in BEGIN or HLT
    always_comb begin
        state_nx  = state;
        ip_op     = IP_HOLD;
        fetch_req = 1'b0;
        fetch_ack = 1'b0;
        instr_ld  = 1'b0;
        case (state)
            ST_BEGIN: begin
                if (int_take) begin
                    state_nx = ST_INT;
                end else if (!bus.ram_txe) begin
                    fetch_req = 1'b1;
                    state_nx  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.ram_txe) begin
                    fetch_ack = 1'b1;
                    if (bus.ram_err) begin
                        state_nx = ST_FAULT;
                    end else begin
                        instr_ld = 1'b1;
                        state_nx = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (bus.ex_done) begin
                    // A halted instruction still advances ip so epc points past it on wake
                    if (bus.ex_hlt) begin
                        ip_op    = IP_INC;
                        state_nx = ST_HLT;
                    end else if (reti_en && bus.ex_reti) begin
                        ip_op    = IP_RETI;
                        state_nx = ST_END;
                    end else if (bus.br_set) begin
                        ip_op    = IP_BR;
                        state_nx = ST_END;
                    end else begin
                        ip_op    = IP_INC;
                        state_nx = ST_END;
                    end
                end
            end
            ST_END:   state_nx = ST_BEGIN;
            ST_HLT:   if (int_take) state_nx = ST_INT;
            ST_INT: begin
                ip_op    = IP_INT;
                state_nx = ST_BEGIN;
            end
            ST_FAULT: state_nx = ST_FAULT;
            default:  state_nx = ST_BEGIN;
        endcase
    end

    // RAM request: raised when leaving BEGIN, dropped once the RAM answers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ram_txs  <= 1'b0;
            bus.ram_re   <= 1'b0;
            bus.ram_addr <= '0;
        end else if (fetch_req) begin
            bus.ram_txs  <= 1'b1;
            bus.ram_re   <= 1'b1;
            bus.ram_addr <= ip;
        end else if (fetch_ack) begin
            bus.ram_txs  <= 1'b0;
            bus.ram_re   <= 1'b0;
        end
    end

    // Instruction latch and one-cycle execute strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.instr    <= '0;
            bus.ex_start <= 1'b0;
        end else begin
            bus.ex_start <= instr_ld;
            if (instr_ld) begin
                bus.instr <= bus.ram_out;
            end
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed bench for cpu_seq. A behavioural RAM and execute unit answer one
// cycle after each request; their behaviour is a fixed program keyed by fetch address.
// Expectations cover both builds (with and without CPU_SEQ_INT_EN).
module tb_cpu_seq;

    localparam int ADDR_W   = 64;
    localparam int INSTR_W  = 32;
    localparam int DEV_ID_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                int_req = 1'b0;
    logic [DEV_ID_W-1:0] int_dev_id = '0;
    logic                int_ack;
    logic [ADDR_W-1:0]   ip;
    logic [ADDR_W-1:0]   epc;
    logic                hlt;
    logic                fault;

    int                  phase = 0;
    int                  cyc = 0;
    int                  n_chk = 0;
    int                  n_err = 0;
    int                  n_ex = 0;
    int                  n_ack = 0;
    logic [ADDR_W-1:0]   flog_a[$];
    int                  flog_c[$];

    cpu_seq_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    cpu_seq #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEV_ID_W (DEV_ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .int_req    (int_req),
        .int_dev_id (int_dev_id),
        .int_ack    (int_ack),
        .ip         (ip),
        .epc        (epc),
        .hlt        (hlt),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Program: what the execute unit / RAM report for the instruction at address a
    function automatic void decode(input logic [63:0] a, input int ph, output bit br,
                                   output logic [63:0] tgt, output bit hl, output bit rt,
                                   output bit er);
        br = 0; tgt = '0; hl = 0; rt = 0; er = 0;
        case (ph)
            0: begin
                if (a == 64'h6)   begin br = 1; tgt = 64'h40; end
                if (a == 64'h41)  begin br = 1; tgt = 64'h7; end
                if (a == 64'h7)   begin hl = 1; br = 1; tgt = 64'h55; end
                if (a == 64'h8)   hl = 1;
                if (a == 64'h10C) begin rt = 1; br = 1; tgt = 64'h77; end
                if (a == 64'h100) rt = 1;
`ifndef CPU_SEQ_INT_EN
                if (a == 64'h40)  rt = 1;
`endif
            end
            1: if (a == 64'h0) begin br = 1; tgt = {64{1'b1}}; end
            default: if (a == 64'h0) er = 1;
        endcase
    endfunction

    // RAM and execute-unit responder
    initial begin : env
        bit          d_br, d_hl, d_rt, d_er;
        logic [63:0] d_tgt;
        bus.ram_txe = 0; bus.ram_err = 0; bus.ram_out = '0;
        bus.ex_done = 0; bus.ex_hlt = 0; bus.ex_reti = 0; bus.br_set = 0; bus.br_addr = '0;
        forever begin
            @(negedge clk);
            decode(bus.ram_addr, phase, d_br, d_tgt, d_hl, d_rt, d_er);
            bus.ram_txe = bus.ram_txs;
            bus.ram_err = bus.ram_txs & d_er;
            bus.ram_out = {16'hC0DE, bus.ram_addr[15:0]};
            bus.ex_done = bus.ex_start;
            bus.ex_hlt  = bus.ex_start & d_hl;
            bus.ex_reti = bus.ex_start & d_rt;
            bus.br_set  = bus.ex_start & d_br;
            bus.br_addr = d_tgt;
        end
    end

    // Fetch log and pulse counters
    initial begin : mon
        forever begin
            @(negedge clk);
            if (bus.ram_txs) begin
                flog_a.push_back(bus.ram_addr);
                flog_c.push_back(cyc);
            end
            if (bus.ex_start) n_ex++;
            if (int_ack) n_ack++;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit probe(input int sel);
        case (sel)
            0:       return hlt;
            1:       return int_ack;
            default: return fault;
        endcase
    endfunction

    task automatic wait_fetch(input logic [63:0] a, input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            ok = bus.ram_txs && (bus.ram_addr == a);
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_probe(input int sel, input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            ok = probe(sel);
        end
        check(tag, ok, 1);
    endtask

    initial begin : main
        int          fb, eb, ab, halt_cyc;
        logic [63:0] ea[$];
        int          ec[$];

`ifdef CPU_SEQ_INT_EN
        ea = '{64'h0, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h10C, 64'h6, 64'h40, 64'h41, 64'h7};
        ec = '{1, 5, 9, 13, 17, 21, 27, 31, 35, 39, 43};
        halt_cyc = 45;
`else
        ea = '{64'h0, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h40, 64'h41, 64'h7};
        ec = '{1, 5, 9, 13, 17, 21, 25, 29, 33, 37};
        halt_cyc = 39;
`endif

        // Reset state
        repeat (2) step();
        check("rst_txs", bus.ram_txs, 0);
        check("rst_re", bus.ram_re, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_ex_start", bus.ex_start, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_ip", ip, 0);
        check("rst_epc", epc, 0);
        check("rst_hlt", hlt, 0);
        check("rst_fault", fault, 0);
        check("rst_ack", int_ack, 0);
        fb = flog_a.size(); eb = n_ex; ab = n_ack;
        rst = 0;

        // Straight-line run, interrupt raised while instruction at ip=5 executes
        wait_fetch(64'h5, 40, "reach_ip5");
        check("fetch5_cyc", cyc, 21);
        check("fetch5_re", bus.ram_re, 1);
        step();
        int_req = 1; int_dev_id = 8'd3;
`ifdef CPU_SEQ_INT_EN
        step();
        check("int_pend_end_ip", ip, 6);
        check("int_pend_end_ack", int_ack, 0);
        wait_probe(1, 10, "int_ack_seen");
        check("int_ack_cyc", cyc, 25);
        check("int_ip_before", ip, 6);
        int_req = 0;
        step();
        check("int_epc", epc, 6);
        check("int_vec", ip, 64'h10C);
        check("int_ack_pulse", int_ack, 0);
        check("int_ack_cnt", n_ack - ab, 1);
`else
        repeat (3) step();
        int_req = 0;
`endif

        // Run up to the halt instruction at 7 (halt wins over a simultaneous branch)
        wait_probe(0, 60, "halt_seen");
        check("halt_cyc", cyc, halt_cyc);
        check("halt_ip", ip, 8);
        check("halt_fault", fault, 0);
        check("halt_instr", bus.instr, 32'hC0DE0007);
        check("fetch_count", flog_a.size() - fb, ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (fb + i < flog_a.size()) begin
                check($sformatf("fetch_addr[%0d]", i), flog_a[fb + i], ea[i]);
                check($sformatf("fetch_cyc[%0d]", i), flog_c[fb + i], ec[i]);
            end
        end
        check("ex_count", n_ex - eb, ea.size());

        // Wake from halt with device 0
        fb = flog_a.size();
        int_dev_id = 8'd0; int_req = 1;
`ifdef CPU_SEQ_INT_EN
        wait_probe(1, 5, "wake_ack");
        int_req = 0;
        step();
        check("wake_epc", epc, 8);
        check("wake_ip", ip, 64'h100);
        check("wake_hlt", hlt, 0);
        wait_probe(0, 30, "rehalt");
        check("rehalt_ip", ip, 9);
        check("rehalt_epc", epc, 8);
        check("rehalt_fetches", flog_a.size() - fb, 2);
        if (flog_a.size() - fb == 2) begin
            check("rehalt_fetch0", flog_a[fb], 64'h100);
            check("rehalt_fetch1", flog_a[fb + 1], 64'h8);
        end
`else
        repeat (8) step();
        check("nowake_hlt", hlt, 1);
        check("nowake_ip", ip, 8);
        check("nowake_epc", epc, 0);
        check("nowake_ack", n_ack - ab, 0);
        check("nowake_fetch", flog_a.size() - fb, 0);
        int_req = 0;
`endif

        // Reset out of halt, then wrap ip from all-ones to 0
        rst = 1; phase = 1;
        step();
        check("rst2_hlt", hlt, 0);
        check("rst2_ip", ip, 0);
        check("rst2_epc", epc, 0);
        check("rst2_instr", bus.instr, 0);
        check("rst2_addr", bus.ram_addr, 0);
        rst = 0;
        wait_fetch({64{1'b1}}, 20, "wrap_fetch_max");
        check("wrap_fetch_cyc", cyc, 5);
        step(); step();
        check("wrap_ip_end", ip, 0);
        wait_fetch(64'h0, 10, "wrap_fetch_zero");
        check("wrap_zero_cyc", cyc, 9);

        // Reset in the middle of a fetch
        wait_fetch({64{1'b1}}, 10, "refetch_max");
        check("pre_rst_ip", ip, {64{1'b1}});
        rst = 1;
        #1;
        check("rst_fetch_txs", bus.ram_txs, 0);
        check("rst_fetch_re", bus.ram_re, 0);
        check("rst_fetch_ip", ip, 0);

        // Fetch error leads to a latched fault
        phase = 2;
        step();
        eb = n_ex;
        rst = 0;
        wait_probe(2, 10, "fault_seen");
        check("fault_cyc", cyc, 2);
        check("fault_hlt", hlt, 1);
        check("fault_instr", bus.instr, 0);
        repeat (5) step();
        check("fault_hold", fault, 1);
        check("fault_hold_hlt", hlt, 1);
        check("fault_txs", bus.ram_txs, 0);
        check("fault_no_ex", n_ex - eb, 0);
        rst = 1;
        #1;
        check("fault_clr", fault, 0);
        check("fault_clr_hlt", hlt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
